// File: rtl/control_fsm_if.sv
// Handshake and control bundle between the sequencer and the 16-bit datapath.
// The sequencer takes the master side; the datapath/memory side takes slave.
interface control_fsm_if;
    logic [15:0] memData;
    logic        memReady;
    logic [15:0] ir;
    logic [15:0] immediate;
    logic [2:0]  busSel;
    logic [3:0]  aluOp;
    logic        regWrite;
    logic [3:0]  regDest;
    logic [3:0]  regSrc;
    logic        memRead;
    logic        memWrite;
    logic        addrSel;
    logic        pcEn;
    logic        pcSel;
    logic [2:0]  state;

    modport master (
        input  memData, memReady,
        output ir, immediate, busSel, aluOp, regWrite, regDest, regSrc,
               memRead, memWrite, addrSel, pcEn, pcSel, state
    );

    modport slave (
        output memData, memReady,
        input  ir, immediate, busSel, aluOp, regWrite, regDest, regSrc,
               memRead, memWrite, addrSel, pcEn, pcSel, state
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle sequencer: FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK.
// State and ir are registered; all strobes decode combinationally from them.
module control_fsm (
    input logic           clk,
    input logic           reset,
    control_fsm_if.master bus
);
    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMem       = 3'd3,
        StWriteback = 3'd4
    } state_t;

    localparam logic [3:0] OpAlu   = 4'h0;
    localparam logic [3:0] OpShift = 4'h1;
    localparam logic [3:0] OpMovi  = 4'h2;
    localparam logic [3:0] OpLoad  = 4'h3;
    localparam logic [3:0] OpStor  = 4'h4;
    localparam logic [3:0] OpJal   = 4'h5;

    localparam logic [2:0] SelAlu   = 3'b000;
    localparam logic [2:0] SelShift = 3'b001;
    localparam logic [2:0] SelImm   = 3'b010;
    localparam logic [2:0] SelMem   = 3'b011;
    localparam logic [2:0] SelPc    = 3'b100;
    localparam logic [2:0] SelRegB  = 3'b101;

    state_t      state_q;
    logic [15:0] ir_q;
    logic [3:0]  opcode;
    logic [2:0]  class_sel;
    logic        writes_reg;
    logic        is_mem_op;

    assign opcode    = ir_q[15:12];
    assign is_mem_op = (opcode == OpLoad) || (opcode == OpStor);

    always_comb begin
        class_sel  = SelAlu;
        writes_reg = 1'b0;
        case (opcode)
            OpAlu:   begin class_sel = SelAlu;   writes_reg = 1'b1; end
            OpShift: begin class_sel = SelShift; writes_reg = 1'b1; end
            OpMovi:  begin class_sel = SelImm;   writes_reg = 1'b1; end
            OpLoad:  begin class_sel = SelMem;   writes_reg = 1'b1; end
            OpStor:  class_sel = SelRegB;
            OpJal:   begin class_sel = SelPc;    writes_reg = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            ir_q    <= '0;
        end else begin
            case (state_q)
                StFetch: if (bus.memReady) state_q <= StDecode;
                StDecode: begin
                    ir_q    <= bus.memData;
                    state_q <= StExecute;
                end
                StExecute: begin
                    if (is_mem_op)       state_q <= StMem;
                    else if (writes_reg) state_q <= StWriteback;
                    else                 state_q <= StFetch;
                end
                StMem: if (bus.memReady) begin
                    state_q <= (opcode == OpLoad) ? StWriteback : StFetch;
                end
                StWriteback: state_q <= StFetch;
                default:     state_q <= StFetch;
            endcase
        end
    end

    logic [2:0] bus_sel;
    logic       reg_write, mem_read, mem_write, addr_sel, pc_en, pc_sel;

    // Reset gates every strobe so an aborted instruction leaves no side effect.
    always_comb begin
        bus_sel   = SelAlu;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr_sel  = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = 1'b0;
        if (!reset) begin
            case (state_q)
                StFetch:   mem_read = 1'b1;
                StDecode:  pc_en = 1'b1;
                StExecute: bus_sel = class_sel;
                StMem: begin
                    addr_sel = 1'b1;
                    if (opcode == OpLoad) mem_read = 1'b1;
                    if (opcode == OpStor) begin
                        mem_write = 1'b1;
                        bus_sel   = SelRegB;
                    end
                end
                StWriteback: begin
                    reg_write = writes_reg;
                    bus_sel   = class_sel;
                    if (opcode == OpJal) begin
                        pc_en  = 1'b1;
                        pc_sel = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ir        = ir_q;
    assign bus.immediate = {{8{ir_q[7]}}, ir_q[7:0]};
    assign bus.aluOp     = ir_q[7:4];
    assign bus.regDest   = ir_q[11:8];
    assign bus.regSrc    = ir_q[3:0];
    assign bus.busSel    = bus_sel;
    assign bus.regWrite  = reg_write;
    assign bus.memRead   = mem_read;
    assign bus.memWrite  = mem_write;
    assign bus.addrSel   = addr_sel;
    assign bus.pcEn      = pc_en;
    assign bus.pcSel     = pc_sel;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench: per-instruction timeline model built from opcode class and stall counts.
module tb_control_fsm;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    control_fsm_if bus();

    control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] ir_m    = 16'h0000;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] sel;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       as;
        logic       pe;
        logic       ps;
    } obs_t;

    function automatic obs_t observe();
        return {bus.state, bus.busSel, bus.regWrite, bus.memRead, bus.memWrite,
                bus.addrSel, bus.pcEn, bus.pcSel};
    endfunction

    // Bus source table for each instruction class.
    function automatic logic [2:0] class_bus(input logic [3:0] op);
        case (op)
            4'h0: return 3'b000;
            4'h1: return 3'b001;
            4'h2: return 3'b010;
            4'h3: return 3'b011;
            4'h4: return 3'b101;
            4'h5: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic obs_t expect_phase(input int ph, input logic [3:0] op);
        obs_t e = '0;
        e.st = 3'(ph);
        case (ph)
            0: e.mr = 1'b1;
            1: e.pe = 1'b1;
            2: e.sel = class_bus(op);
            3: begin
                e.as = 1'b1;
                if (op == 4'h3) e.mr = 1'b1;
                else begin
                    e.mw  = 1'b1;
                    e.sel = 3'b101;
                end
            end
            4: begin
                e.rw  = 1'b1;
                e.sel = class_bus(op);
                if (op == 4'h5) begin
                    e.pe = 1'b1;
                    e.ps = 1'b1;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic step(input logic rdy, input logic [15:0] data);
        @(negedge clk);
        bus.memReady = rdy;
        bus.memData  = data;
        #1;
    endtask

    // Walks one instruction from its first FETCH cycle to its last cycle.
    task automatic run_instr(input string tag, input logic [15:0] instr,
                             input int fstall, input int mstall);
        logic [3:0]  op = instr[15:12];
        int          phases[$];
        bit          readys[$];
        obs_t        got, exp;
        logic [47:0] fg, fe;
        for (int i = 0; i <= fstall; i++) begin
            phases.push_back(0);
            readys.push_back(i == fstall);
        end
        phases.push_back(1); readys.push_back(1'($urandom));
        phases.push_back(2); readys.push_back(1'($urandom));
        if (op == 4'h3 || op == 4'h4) begin
            for (int j = 0; j <= mstall; j++) begin
                phases.push_back(3);
                readys.push_back(j == mstall);
            end
        end
        if (op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5}) begin
            phases.push_back(4);
            readys.push_back(1'($urandom));
        end
        for (int k = 0; k < phases.size(); k++) begin
            step(readys[k], (phases[k] == 1) ? instr : 16'($urandom));
            exp = expect_phase(phases[k], op);
            got = observe();
            n_total++;
            if (got !== exp)
                $display("FAIL %s ctrl cycle %0d: got %b required %b", tag, k, got, exp);
            else n_pass++;
            fg = {bus.ir, bus.immediate, bus.aluOp, bus.regDest, bus.regSrc, 4'h0};
            fe = {ir_m, {{8{ir_m[7]}}, ir_m[7:0]}, ir_m[7:4], ir_m[11:8], ir_m[3:0], 4'h0};
            n_total++;
            if (fg !== fe)
                $display("FAIL %s fields cycle %0d: got %h required %h", tag, k, fg, fe);
            else n_pass++;
            if (phases[k] == 1) ir_m = instr;
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.memReady = 1'b1;
        bus.memData  = 16'h5E03;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_total++;
        if (observe() !== obs_t'(0)) $display("FAIL reset ctrl: got %b required 0", observe());
        else n_pass++;
        n_total++;
        if ({bus.ir, bus.immediate, bus.aluOp, bus.regDest, bus.regSrc} !== 44'h0)
            $display("FAIL reset fields: got ir %h imm %h required 0", bus.ir, bus.immediate);
        else n_pass++;
        bus.memReady = 1'b0;
        reset        = 1'b0;
        ir_m         = 16'h0000;
    endtask

    task automatic test_alu();
        run_instr("alu", 16'h0152, 0, 0);
        n_total++;
        if ({bus.aluOp, bus.regDest, bus.regSrc} !== 12'h512)
            $display("FAIL alu fields: got %h required 512", {bus.aluOp, bus.regDest, bus.regSrc});
        else n_pass++;
    endtask

    task automatic test_movi();
        run_instr("movi", 16'h23F0, 0, 0);
        n_total++;
        if (bus.immediate !== 16'hFFF0)
            $display("FAIL movi immediate: got %h required fff0", bus.immediate);
        else n_pass++;
        run_instr("movi80", 16'h2080, 1, 0);
        n_total++;
        if (bus.immediate !== 16'hFF80)
            $display("FAIL movi80 immediate: got %h required ff80", bus.immediate);
        else n_pass++;
    endtask

    task automatic test_mem_ops();
        run_instr("load_stall", 16'h3405, 2, 3);
        run_instr("stor", 16'h4607, 0, 0);
        run_instr("stor_stall", 16'h4607, 1, 2);
    endtask

    task automatic test_jal_nop();
        run_instr("jal", 16'h5E03, 0, 0);
        run_instr("nop", 16'hF000, 0, 0);
        run_instr("nop2", 16'h9ABC, 1, 0);
    endtask

    task automatic test_reset_mid_mem();
        step(1'b1, 16'h1234);
        step(1'b0, 16'h4607);
        step(1'b0, 16'h0000);
        step(1'b0, 16'h0000);
        n_total++;
        if (bus.state !== 3'd3 || bus.memWrite !== 1'b1)
            $display("FAIL midmem pre: got state %0d memWrite %b required 3 1",
                     bus.state, bus.memWrite);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_total++;
        if ({bus.memWrite, bus.pcEn, bus.regWrite, bus.memRead, bus.addrSel, bus.busSel} !== 8'h0)
            $display("FAIL midmem in-reset strobes: got memWrite %b pcEn %b busSel %b required 0",
                     bus.memWrite, bus.pcEn, bus.busSel);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if (bus.state !== 3'd0 || bus.ir !== 16'h0 || bus.pcEn !== 1'b0 || bus.memRead !== 1'b1)
            $display("FAIL midmem after: got state %0d ir %h pcEn %b required 0 0000 0",
                     bus.state, bus.ir, bus.pcEn);
        else n_pass++;
        ir_m = 16'h0000;
        run_instr("post_reset", 16'h1ABC, 0, 0);
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] r;
        for (int n = 0; n < 40; n++) begin
            r  = $urandom;
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(0, 5));
            run_instr("random", {op, r[11:0]}, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        bus.memReady = 1'b0;
        bus.memData  = 16'h0;
        test_reset();
        test_alu();
        test_movi();
        test_mem_ops();
        test_jal_nop();
        test_reset_mid_mem();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
